noc_traffic_node: RTL and testbench
===================================

NOC_TRAFFIC_NODE -- requirements
Module: noc_traffic_node

Interface
REQ-001 Parameter DATA_WIDTH, default 32: flit width in bits.
REQ-002 Parameter COORD_W, default 4: width of each X/Y coordinate field.
REQ-003 Parameter NODE_X, default 0: X coordinate of this node.
REQ-004 Parameter NODE_Y, default 0: Y coordinate of this node.
REQ-005 Parameter LEN_W, default 4: width of the packet-length field (max 2^LEN_W-1 flits).
REQ-006 noc_clk  in  1  single clock; all logic on its rising edge.
REQ-007 noc_rst  in  1  reset, asynchronous, active-high.
REQ-008 gen_start  in  1  request one packet; sampled only in TX IDLE.
REQ-009 gen_dst_x, gen_dst_y  in  COORD_W each  destination of the requested packet.
REQ-010 gen_len  in  LEN_W  total flits including header; 0 is treated as 1.
REQ-011 rx_hold  in  1  forces receive_ready low (backpressure injection).
REQ-012 sender_valid, sender_flit, sender_is_header, sender_is_tail  out  1/DATA_WIDTH/1/1  flit toward router.
REQ-013 sender_ready  in  1  router accepts sender flit.
REQ-014 receive_valid, receive_flit, receive_is_header, receive_is_tail  in  1/DATA_WIDTH/1/1  flit from router.
REQ-015 receive_ready  out  1  node accepts receive flit.
REQ-016 tx_busy  out  1  high when TX is not IDLE.
REQ-017 pkt_sent_cnt, pkt_recv_cnt, err_cnt  out  16 each  statistics counters.

Function
REQ-018 SEQ_W = DATA_WIDTH-4*COORD_W; elaboration SHALL fail if SEQ_W < 1.
REQ-019 Header flit layout, MSB first: {dst_x, dst_y, NODE_X, NODE_Y, seq}; seq is a SEQ_W-bit packet counter, reset 0, incremented (wrapping) after each sent tail.
REQ-020 Body flit k (k = 1..len-1) = header flit + k, modulo 2^DATA_WIDTH.
REQ-021 TX FSM states IDLE, SEND; IDLE->SEND on gen_start, latching dst and len (0->1); registered outputs, sender_valid rises the cycle after gen_start is sampled.
REQ-022 A flit transfers on sender_valid & sender_ready; flit, is_header, is_tail SHALL stay stable while valid & !ready.
REQ-023 sender_is_header high on flit 0 only; sender_is_tail high on flit len-1 only; len=1 packet has both high on one flit.
REQ-024 Back-to-back flits: next flit presented the cycle after a transfer, no bubble; SEND->IDLE on tail transfer, pkt_sent_cnt +1 that edge.
REQ-025 gen_start while in SEND SHALL be ignored.
REQ-026 receive_ready = !rx_hold & !noc_rst (combinational); a receive transfer is receive_valid & receive_ready.
REQ-027 RX FSM states WAIT_HEAD, BODY; holds stored header H and index k.
REQ-028 WAIT_HEAD: header transfer -> store H, k=1; go BODY unless is_tail also high (then packet complete). Non-header transfer -> err_cnt +1, stay.
REQ-029 Header check: dst fields != {NODE_X,NODE_Y} -> err_cnt +1 once; packet still consumed.
REQ-030 BODY: flit != H+k -> err_cnt +1; k increments per transfer; tail -> WAIT_HEAD.
REQ-031 Header received in BODY -> err_cnt +1, treat as new header (restart per REQ-028).
REQ-032 pkt_recv_cnt +1 on each tail transfer that completes a packet (including len=1).
REQ-033 At most one err_cnt increment per transfer cycle; all three counters saturate at 16'hFFFF.
REQ-034 Simultaneous TX and RX activity SHALL be fully independent.

Reset
REQ-035 On noc_rst high, immediately: TX IDLE, RX WAIT_HEAD, sender_valid/is_header/is_tail 0, sender_flit 0, seq 0, all counters 0, tx_busy 0.
REQ-036 Reset mid-packet SHALL abandon the packet; no counter increments for it after release.

Verification
REQ-037 DATA_WIDTH=32, COORD_W=4, NODE=(1,0), gen_len=4, dst=(0,1), sender_ready=1 -> flits 0x0110_0000, 0x0110_0001, 0x0110_0002, 0x0110_0003, header/tail on first/last, pkt_sent_cnt=1.
REQ-038 Same packet, sender_ready toggling 1-0-1 each cycle -> flits held stable during ready=0, order intact, 4 transfers total.
REQ-039 Loopback sender->receive at NODE=(1,0), dst=(1,0), gen_len=0 -> single flit with header and tail high, pkt_recv_cnt=1, err_cnt=0.
REQ-040 Inject header with dst=(2,2) plus one body at NODE=(1,0) -> err_cnt=1, pkt_recv_cnt=1.
REQ-041 Inject body flit with no header, then header in BODY state -> err_cnt=2.
REQ-042 Assert noc_rst during flit 2 of a 4-flit packet -> outputs zero immediately; after release new packet has seq=0.

Source files
------------

// File: rtl/noc_traffic_node.sv
// NoC traffic endpoint: generates self-describing test packets toward a router and
// checks incoming packets against the same header-plus-index pattern.
module noc_traffic_node #(
   parameter int DATA_WIDTH = 32,
   parameter int COORD_W    = 4,
   parameter int NODE_X     = 0,
   parameter int NODE_Y     = 0,
   parameter int LEN_W      = 4
) (
   input  logic                  noc_clk,
   input  logic                  noc_rst,
   input  logic                  gen_start,
   input  logic [COORD_W-1:0]    gen_dst_x,
   input  logic [COORD_W-1:0]    gen_dst_y,
   input  logic [LEN_W-1:0]      gen_len,
   input  logic                  rx_hold,
   output logic                  sender_valid,
   output logic [DATA_WIDTH-1:0] sender_flit,
   output logic                  sender_is_header,
   output logic                  sender_is_tail,
   input  logic                  sender_ready,
   input  logic                  receive_valid,
   input  logic [DATA_WIDTH-1:0] receive_flit,
   input  logic                  receive_is_header,
   input  logic                  receive_is_tail,
   output logic                  receive_ready,
   output logic                  tx_busy,
   output logic [15:0]           pkt_sent_cnt,
   output logic [15:0]           pkt_recv_cnt,
   output logic [15:0]           err_cnt
);

   localparam int SEQ_W = DATA_WIDTH - 4 * COORD_W;
   localparam logic [COORD_W-1:0] NODE_XC = COORD_W'(NODE_X);
   localparam logic [COORD_W-1:0] NODE_YC = COORD_W'(NODE_Y);

   generate
      if (SEQ_W < 1) begin : gBadWidth
         $error("noc_traffic_node: DATA_WIDTH too small to hold four coordinates and a sequence number");
      end
   endgenerate

   typedef enum logic {TX_IDLE, TX_SEND} txState_e;
   typedef enum logic {RX_WAIT_HEAD, RX_BODY} rxState_e;

   txState_e              txState_q;
   logic [LEN_W-1:0]      txLen_q;
   logic [LEN_W-1:0]      txIdx_q;
   logic [SEQ_W-1:0]      seq_q;
   logic                  txValid_q;
   logic [DATA_WIDTH-1:0] txFlit_q;
   logic                  txHeader_q;
   logic                  txTail_q;
   logic [15:0]           sentCnt_q;

   rxState_e              rxState_q;
   logic [DATA_WIDTH-1:0] rxHead_q;
   logic [DATA_WIDTH-1:0] rxIdx_q;
   logic [15:0]           recvCnt_q;
   logic [15:0]           errCnt_q;

   logic [LEN_W-1:0]      lenEff;
   logic [LEN_W-1:0]      txIdxNext;
   logic [DATA_WIDTH-1:0] headerFlit;
   logic                  txFire;
   logic                  rxFire;
   logic                  rxDstOk;
   logic                  rxErr;
   logic                  rxDone;

   assign lenEff     = (gen_len == '0) ? LEN_W'(1) : gen_len;
   assign txIdxNext  = txIdx_q + LEN_W'(1);
   assign headerFlit = {gen_dst_x, gen_dst_y, NODE_XC, NODE_YC, seq_q};
   assign txFire     = txValid_q & sender_ready;

   // Every body flit is the header plus its index, so the next flit is just the
   // current one plus one; tail is flagged when the next index reaches len-1.
   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         txState_q  <= TX_IDLE;
         txLen_q    <= '0;
         txIdx_q    <= '0;
         seq_q      <= '0;
         txValid_q  <= 1'b0;
         txFlit_q   <= '0;
         txHeader_q <= 1'b0;
         txTail_q   <= 1'b0;
         sentCnt_q  <= '0;
      end else begin
         case (txState_q)
            TX_IDLE: begin
               if (gen_start) begin
                  txState_q  <= TX_SEND;
                  txLen_q    <= lenEff;
                  txIdx_q    <= '0;
                  txValid_q  <= 1'b1;
                  txFlit_q   <= headerFlit;
                  txHeader_q <= 1'b1;
                  txTail_q   <= (lenEff == LEN_W'(1));
               end
            end
            TX_SEND: begin
               if (txFire) begin
                  if (txTail_q) begin
                     txState_q  <= TX_IDLE;
                     txValid_q  <= 1'b0;
                     txFlit_q   <= '0;
                     txHeader_q <= 1'b0;
                     txTail_q   <= 1'b0;
                     seq_q      <= seq_q + SEQ_W'(1);
                     if (sentCnt_q != 16'hFFFF) begin
                        sentCnt_q <= sentCnt_q + 16'd1;
                     end
                  end else begin
                     txIdx_q    <= txIdxNext;
                     txFlit_q   <= txFlit_q + DATA_WIDTH'(1);
                     txHeader_q <= 1'b0;
                     txTail_q   <= (txIdxNext == txLen_q - LEN_W'(1));
                  end
               end
            end
         endcase
      end
   end

   assign receive_ready = ~rx_hold & ~noc_rst;
   assign rxFire        = receive_valid & receive_ready;
   assign rxDstOk       = (receive_flit[DATA_WIDTH-1 -: 2*COORD_W] == {NODE_XC, NODE_YC});

   // A single error flag per transfer: a header arriving mid-packet already counts
   // as one error, so a bad destination on that same header adds nothing more.
   always_comb begin
      rxErr  = 1'b0;
      rxDone = 1'b0;
      if (rxFire) begin
         if (receive_is_header) begin
            rxErr  = (rxState_q == RX_BODY) | ~rxDstOk;
            rxDone = receive_is_tail;
         end else if (rxState_q == RX_WAIT_HEAD) begin
            rxErr = 1'b1;
         end else begin
            rxErr  = (receive_flit != rxHead_q + rxIdx_q);
            rxDone = receive_is_tail;
         end
      end
   end

   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         rxState_q <= RX_WAIT_HEAD;
         rxHead_q  <= '0;
         rxIdx_q   <= '0;
      end else if (rxFire) begin
         if (receive_is_header) begin
            rxHead_q  <= receive_flit;
            rxIdx_q   <= DATA_WIDTH'(1);
            rxState_q <= receive_is_tail ? RX_WAIT_HEAD : RX_BODY;
         end else if (rxState_q == RX_BODY) begin
            rxIdx_q <= rxIdx_q + DATA_WIDTH'(1);
            if (receive_is_tail) begin
               rxState_q <= RX_WAIT_HEAD;
            end
         end
      end
   end

   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         recvCnt_q <= '0;
         errCnt_q  <= '0;
      end else begin
         if (rxDone && recvCnt_q != 16'hFFFF) begin
            recvCnt_q <= recvCnt_q + 16'd1;
         end
         if (rxErr && errCnt_q != 16'hFFFF) begin
            errCnt_q <= errCnt_q + 16'd1;
         end
      end
   end

   assign sender_valid     = txValid_q;
   assign sender_flit      = txFlit_q;
   assign sender_is_header = txHeader_q;
   assign sender_is_tail   = txTail_q;
   assign tx_busy          = (txState_q == TX_SEND);
   assign pkt_sent_cnt     = sentCnt_q;
   assign pkt_recv_cnt     = recvCnt_q;
   assign err_cnt          = errCnt_q;

endmodule

// File: tb/tb_noc_traffic_node.sv
// Randomised and directed bench for noc_traffic_node at NODE=(1,0), checked against
// a packet-level reference model held in queues and counters.
module tb_noc_traffic_node;

   logic        noc_clk = 1'b0;
   logic        noc_rst = 1'b0;
   logic        gen_start = 1'b0;
   logic [3:0]  gen_dst_x = '0;
   logic [3:0]  gen_dst_y = '0;
   logic [3:0]  gen_len = '0;
   logic        rx_hold = 1'b0;
   logic        sender_valid, sender_is_header, sender_is_tail, sender_ready;
   logic [31:0] sender_flit;
   logic        receive_valid, receive_is_header, receive_is_tail, receive_ready;
   logic [31:0] receive_flit;
   logic        tx_busy;
   logic [15:0] pkt_sent_cnt, pkt_recv_cnt, err_cnt;

   logic        loopback = 1'b0;
   logic        tbReady = 1'b1;
   logic        injValid = 1'b0, injHdr = 1'b0, injTail = 1'b0;
   logic [31:0] injFlit = '0;
   int          readyMode = 0;

   assign sender_ready      = loopback ? receive_ready : tbReady;
   assign receive_valid     = loopback ? sender_valid : injValid;
   assign receive_flit      = loopback ? sender_flit : injFlit;
   assign receive_is_header = loopback ? sender_is_header : injHdr;
   assign receive_is_tail   = loopback ? sender_is_tail : injTail;

   noc_traffic_node #(
      .DATA_WIDTH(32), .COORD_W(4), .NODE_X(1), .NODE_Y(0), .LEN_W(4)
   ) dut (
      .noc_clk(noc_clk), .noc_rst(noc_rst),
      .gen_start(gen_start), .gen_dst_x(gen_dst_x), .gen_dst_y(gen_dst_y), .gen_len(gen_len),
      .rx_hold(rx_hold),
      .sender_valid(sender_valid), .sender_flit(sender_flit),
      .sender_is_header(sender_is_header), .sender_is_tail(sender_is_tail),
      .sender_ready(sender_ready),
      .receive_valid(receive_valid), .receive_flit(receive_flit),
      .receive_is_header(receive_is_header), .receive_is_tail(receive_is_tail),
      .receive_ready(receive_ready),
      .tx_busy(tx_busy),
      .pkt_sent_cnt(pkt_sent_cnt), .pkt_recv_cnt(pkt_recv_cnt), .err_cnt(err_cnt)
   );

   always #5 noc_clk = ~noc_clk;

   typedef struct {
      logic [31:0] flit;
      logic        hdr;
      logic        tail;
   } txExp_t;

   txExp_t      txQ[$];
   logic [31:0] obsLog[$];
   logic        modelBusy, tailPending, rxInBody, prevStall, prevHdr, prevTail;
   logic [15:0] modelSeq, modelSent, modelRecv, modelErr;
   logic [31:0] rxH, rxK, prevFlit;
   int          passCount = 0;
   int          checkCount = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   function automatic logic [15:0] sat16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic modelReset();
      txQ.delete();
      modelBusy = 0; tailPending = 0; rxInBody = 0; prevStall = 0;
      modelSeq = 0; modelSent = 0; modelRecv = 0; modelErr = 0;
      rxH = 0; rxK = 0; prevFlit = 0; prevHdr = 0; prevTail = 0;
   endtask

   // Receive rules at packet level: a packet is a valid header followed by body
   // flits equal to header+index; anything else costs exactly one error.
   task automatic modelRx(input logic [31:0] f, input logic h, input logic t);
      if (h) begin
         if (rxInBody || f[31:24] != 8'h10) modelErr = sat16(modelErr);
         rxH = f;
         rxK = 1;
         if (t) begin
            modelRecv = sat16(modelRecv);
            rxInBody = 0;
         end else begin
            rxInBody = 1;
         end
      end else if (!rxInBody) begin
         modelErr = sat16(modelErr);
      end else begin
         if (f != rxH + rxK) modelErr = sat16(modelErr);
         rxK = rxK + 1;
         if (t) begin
            modelRecv = sat16(modelRecv);
            rxInBody = 0;
         end
      end
   endtask

   task automatic monitor();
      txExp_t e;
      checkOutput("sentCnt", pkt_sent_cnt, modelSent);
      checkOutput("recvCnt", pkt_recv_cnt, modelRecv);
      checkOutput("errCnt", err_cnt, modelErr);
      checkOutput("txBusy", tx_busy, modelBusy);
      checkOutput("rxReady", receive_ready, !rx_hold && !noc_rst);
      if (prevStall) begin
         checkOutput("holdValid", sender_valid, 1'b1);
         checkOutput("holdFlit", sender_flit, prevFlit);
         checkOutput("holdFlags", {sender_is_header, sender_is_tail}, {prevHdr, prevTail});
      end
      if (sender_valid && sender_ready) begin
         if (txQ.size() == 0) begin
            checkOutput("txUnexpected", sender_valid, 1'b0);
         end else begin
            e = txQ.pop_front();
            checkOutput("txFlit", sender_flit, e.flit);
            checkOutput("txHdr", sender_is_header, e.hdr);
            checkOutput("txTail", sender_is_tail, e.tail);
            obsLog.push_back(sender_flit);
            if (e.tail) begin
               tailPending = 1;
               modelSent = sat16(modelSent);
            end
         end
      end
      prevStall = sender_valid && !sender_ready;
      prevFlit  = sender_flit;
      prevHdr   = sender_is_header;
      prevTail  = sender_is_tail;
      if (receive_valid && receive_ready) modelRx(receive_flit, receive_is_header, receive_is_tail);
   endtask

   task automatic edgeUpdate();
      logic        accept;
      int          n;
      logic [31:0] h;
      if (!noc_rst) begin
         accept = gen_start && !modelBusy;
         if (tailPending) begin
            modelBusy = 0;
            tailPending = 0;
            modelSeq = modelSeq + 16'd1;
         end
         if (accept) begin
            n = (gen_len == 0) ? 1 : int'(gen_len);
            h = {gen_dst_x, gen_dst_y, 4'd1, 4'd0, modelSeq};
            for (int k = 0; k < n; k++) txQ.push_back('{flit: h + 32'(k), hdr: (k == 0), tail: (k == n - 1)});
            modelBusy = 1;
         end
      end
   endtask

   task automatic step();
      @(negedge noc_clk);
      monitor();
      @(posedge noc_clk);
      edgeUpdate();
      #1;
      case (readyMode)
         0:       tbReady = 1'b1;
         1:       tbReady = !tbReady;
         default: tbReady = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (modelBusy || txQ.size() > 0); i++) step();
      checkOutput("drainTimeout", modelBusy, 1'b0);
   endtask

   task automatic applyStimulus(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] len);
      gen_dst_x = dx; gen_dst_y = dy; gen_len = len;
      gen_start = 1'b1;
      step();
      gen_start = 1'b0;
   endtask

   task automatic injectFlit(input logic [31:0] f, input logic h, input logic t);
      injValid = 1'b1; injFlit = f; injHdr = h; injTail = t;
      step();
      injValid = 1'b0; injHdr = 1'b0; injTail = 1'b0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "Valid"}, sender_valid, 1'b0);
      checkOutput({tag, "Flit"}, sender_flit, 32'h0);
      checkOutput({tag, "Flags"}, {sender_is_header, sender_is_tail}, 2'b00);
      checkOutput({tag, "Busy"}, tx_busy, 1'b0);
      checkOutput({tag, "Counters"}, {pkt_sent_cnt, pkt_recv_cnt, err_cnt}, 48'h0);
      checkOutput({tag, "RxReady"}, receive_ready, 1'b0);
   endtask

   // Directed scenarios first, then a long mixed run with random TX and RX traffic.
   initial begin
      logic [15:0] recvBase, errBase;
      logic [31:0] f;
      logic [31:0] injH, injK;
      int          kind;

      modelReset();
      injH = 0; injK = 0;
      #1 noc_rst = 1'b1;
      #1 checkResetOutputs("rst");
      step(); step();
      noc_rst = 1'b0;

      readyMode = 0;
      obsLog.delete();
      applyStimulus(4'd0, 4'd1, 4'd4);
      drain();
      checkOutput("basicCount", obsLog.size(), 4);
      for (int i = 0; i < 4 && i < obsLog.size(); i++) checkOutput("basicFlit", obsLog[i], 32'h0110_0000 + 32'(i));
      checkOutput("basicSent", pkt_sent_cnt, 16'd1);

      readyMode = 1;
      obsLog.delete();
      applyStimulus(4'd0, 4'd1, 4'd4);
      drain();
      readyMode = 0;
      checkOutput("toggleCount", obsLog.size(), 4);
      for (int i = 0; i < 4 && i < obsLog.size(); i++) checkOutput("toggleFlit", obsLog[i], 32'h0110_0001 + 32'(i));

      loopback = 1'b1;
      recvBase = modelRecv; errBase = modelErr;
      obsLog.delete();
      applyStimulus(4'd1, 4'd0, 4'd0);
      drain();
      step();
      loopback = 1'b0;
      checkOutput("loopCount", obsLog.size(), 1);
      if (obsLog.size() > 0) checkOutput("loopFlit", obsLog[0], 32'h1010_0002);
      checkOutput("loopRecv", pkt_recv_cnt, recvBase + 16'd1);
      checkOutput("loopErr", err_cnt, errBase);

      recvBase = modelRecv; errBase = modelErr;
      injectFlit(32'h2210_0005, 1'b1, 1'b0);
      injectFlit(32'h2210_0006, 1'b0, 1'b1);
      step();
      checkOutput("badDstErr", err_cnt, errBase + 16'd1);
      checkOutput("badDstRecv", pkt_recv_cnt, recvBase + 16'd1);

      recvBase = modelRecv; errBase = modelErr;
      injectFlit(32'h1010_0000, 1'b0, 1'b0);
      injectFlit(32'h1010_0007, 1'b1, 1'b0);
      injectFlit(32'h1010_0009, 1'b1, 1'b0);
      injectFlit(32'h1010_000A, 1'b0, 1'b1);
      step();
      checkOutput("orphanErr", err_cnt, errBase + 16'd2);
      checkOutput("orphanRecv", pkt_recv_cnt, recvBase + 16'd1);

      obsLog.delete();
      applyStimulus(4'd0, 4'd1, 4'd4);
      for (int i = 0; i < 20 && obsLog.size() < 2; i++) step();
      checkOutput("midProgress", obsLog.size(), 2);
      #2 noc_rst = 1'b1;
      #1 checkResetOutputs("midRst");
      modelReset();
      obsLog.delete();
      step(); step();
      noc_rst = 1'b0;
      step();
      applyStimulus(4'd0, 4'd1, 4'd4);
      drain();
      checkOutput("postRstCount", obsLog.size(), 4);
      if (obsLog.size() > 0) checkOutput("postRstHeader", obsLog[0], 32'h0110_0000);
      checkOutput("postRstSent", pkt_sent_cnt, 16'd1);

      readyMode = 2;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         gen_start = ($urandom_range(0, 3) == 0);
         gen_dst_x = 4'($urandom);
         gen_dst_y = 4'($urandom);
         gen_len   = 4'($urandom);
         rx_hold   = ($urandom_range(0, 3) == 0);
         injValid  = 1'($urandom_range(0, 1));
         injTail   = ($urandom_range(0, 2) == 0);
         kind      = $urandom_range(0, 3);
         injHdr    = (kind < 2);
         case (kind)
            0: begin f = {4'd1, 4'd0, 4'($urandom), 4'($urandom), 16'($urandom)}; injH = f; injK = 1; end
            1: begin f = $urandom; injH = f; injK = 1; end
            2: begin f = injH + injK; injK = injK + 1; end
            default: f = $urandom;
         endcase
         injFlit = f;
         step();
      end
      gen_start = 1'b0; injValid = 1'b0; rx_hold = 1'b0; readyMode = 0;
      drain();
      step();
      checkOutput("finalSent", pkt_sent_cnt, modelSent);
      checkOutput("finalRecv", pkt_recv_cnt, modelRecv);
      checkOutput("finalErr", err_cnt, modelErr);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
